// File: rtl/r5p_bus_if.sv
// Simple valid/ready memory bus shared by SoC managers and subordinates.
// A transfer completes on vld && rdy; read data returns the following cycle.
interface r5p_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          vld;
  logic          wen;
  logic [BW-1:0] ben;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport man (
    output vld, wen, ben, adr, wdt,
    input  rdt, rdy
  );

  modport sub (
    input  vld, wen, ben, adr, wdt,
    output rdt, rdy
  );
endinterface

// File: rtl/r5p_soc_dma.sv
// Single-channel word-copy DMA manager: reads len words from src and writes
// them to dst in ascending order, one read and one write per word.
//
// state | meaning
// IDLE  | waiting for start, bus idle
// RD    | read request to src_reg outstanding
// RDW   | read data returning, captured into dbuf
// WR    | write request of dbuf to dst_reg outstanding
// FIN   | one-cycle done pulse
module r5p_soc_dma #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = DW / 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  r5p_bus_if.man        bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RDW  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  localparam logic [AW-1:0] STEP  = AW'(BW);
  localparam logic [AW-1:0] AMASK = ~(AW'(BW) - AW'(1));

  logic [2:0]    state;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [LW-1:0] cnt;
  logic [DW-1:0] dbuf;
  logic          wen_r;
  logic [BW-1:0] ben_r;
  logic [AW-1:0] adr_r;
  logic [DW-1:0] wdt_r;

  // Outputs are pure decodes of registered state; bus fields are registers
  // loaded on state entry so they stay stable while stalled.
  assign busy    = (state == RD) || (state == RDW) || (state == WR);
  assign done    = (state == FIN);
  assign bus.vld = (state == RD) || (state == WR);
  assign bus.wen = wen_r;
  assign bus.ben = ben_r;
  assign bus.adr = adr_r;
  assign bus.wdt = wdt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_reg <= '0;
      dst_reg <= '0;
      cnt     <= '0;
      dbuf    <= '0;
      wen_r   <= 1'b0;
      ben_r   <= '0;
      adr_r   <= '0;
      wdt_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_reg <= src & AMASK;
            dst_reg <= dst & AMASK;
            cnt     <= len;
            if (len == '0) begin
              state <= FIN;
            end else begin
              state <= RD;
              adr_r <= src & AMASK;
              wen_r <= 1'b0;
              ben_r <= '1;
            end
          end
        end
        RD: begin
          if (bus.rdy) state <= RDW;
        end
        RDW: begin
          dbuf  <= bus.rdt;
          wdt_r <= bus.rdt;
          adr_r <= dst_reg;
          wen_r <= 1'b1;
          ben_r <= '1;
          state <= WR;
        end
        WR: begin
          if (bus.rdy) begin
            src_reg <= src_reg + STEP;
            dst_reg <= dst_reg + STEP;
            cnt     <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              state <= FIN;
            end else begin
              state <= RD;
              adr_r <= src_reg + STEP;
              wen_r <= 1'b0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // dbuf mirrors the captured word; wdt_r is the bus-facing copy.
  logic unused_dbuf;
  assign unused_dbuf = ^dbuf;
endmodule

// File: tb/tb_r5p_soc_dma.sv
// Randomized bench for r5p_soc_dma: reactive memory subordinate plus a
// word-level copy reference model.
module tb_r5p_soc_dma;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done;

  r5p_bus_if #(.AW(32), .DW(32)) bus_if ();

  r5p_soc_dma #(.AW(32), .DW(32), .BW(4), .LW(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents; unwritten words read back a pattern derived from the address.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  bit          stall_en = 0;
  bit          pending = 0;
  bit          stalled = 0;
  logic [31:0] padr;
  logic [31:0] s_adr, s_wdt;
  logic        s_wen;
  int          n_stall, n_vld;
  logic [31:0] wq_adr[$], wq_dat[$], rq_adr[$];

  // Subordinate: just after each falling edge, decide rdy for the next rising edge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      bus_if.rdy = 1'b0;
      pending    = 0;
      stalled    = 0;
    end else begin
      if (pending) begin
        bus_if.rdt = mem.exists(padr) ? mem[padr] : dflt(padr);
        pending    = 0;
      end else begin
        bus_if.rdt = $urandom;
      end
      if (stalled) begin
        check("stall_vld", {31'd0, bus_if.vld}, 32'd1);
        check("stall_adr", bus_if.adr, s_adr);
        check("stall_wen", {31'd0, bus_if.wen}, {31'd0, s_wen});
        if (s_wen) check("stall_wdt", bus_if.wdt, s_wdt);
      end
      bus_if.rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (bus_if.vld) begin
        n_vld++;
        if (bus_if.rdy) begin
          if (bus_if.wen) begin
            check("wr_ben", {28'd0, bus_if.ben}, 32'hF);
            mem[bus_if.adr] = bus_if.wdt;
            wq_adr.push_back(bus_if.adr);
            wq_dat.push_back(bus_if.wdt);
          end else begin
            pending = 1;
            padr    = bus_if.adr;
            rq_adr.push_back(bus_if.adr);
          end
        end else begin
          stalled = 1;
          n_stall++;
          s_adr = bus_if.adr;
          s_wen = bus_if.wen;
          s_wdt = bus_if.wdt;
        end
      end
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int disturb);
    logic [31:0] rm [logic [31:0]];
    logic [31:0] e_wa[$], e_wd[$], e_ra[$];
    logic [31:0] sa, da, ra, wa, v;
    int busy_n, done_n, done_at;
    rm = mem;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(n); i++) begin
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      v  = rm.exists(ra) ? rm[ra] : dflt(ra);
      rm[wa] = v;
      e_ra.push_back(ra);
      e_wa.push_back(wa);
      e_wd.push_back(v);
    end
    wq_adr.delete(); wq_dat.delete(); rq_adr.delete();
    n_stall = 0; n_vld = 0;
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src = $urandom; dst = $urandom; len = 16'($urandom);
    busy_n = 0; done_n = 0; done_at = 0;
    for (int c = 1; c <= 600; c++) begin
      if (c == disturb) begin
        start = 1'b1; src = s + 32'h40; len = n + 16'd3;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (done_at != 0 && c >= done_at + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", done_at, 3 * int'(n) + 1 + n_stall);
    check("busy_cycles", busy_n, 3 * int'(n) + n_stall);
    check("done_count", done_n, 1);
    check("vld_cycles", n_vld, 2 * int'(n) + n_stall);
    check("wr_count", wq_adr.size(), e_wa.size());
    check("rd_count", rq_adr.size(), e_ra.size());
    for (int i = 0; i < e_wa.size() && i < wq_adr.size(); i++) begin
      check("wr_adr", wq_adr[i], e_wa[i]);
      check("wr_dat", wq_dat[i], e_wd[i]);
    end
    for (int i = 0; i < e_ra.size() && i < rq_adr.size(); i++)
      check("rd_adr", rq_adr[i], e_ra[i]);
  endtask

  initial begin
    int c, done_n;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    bus_if.rdy = 1'b0; bus_if.rdt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_vld", {31'd0, bus_if.vld}, 0);
    check("rst_wen", {31'd0, bus_if.wen}, 0);
    check("rst_ben", {28'd0, bus_if.ben}, 0);
    check("rst_adr", bus_if.adr, 0);
    check("rst_wdt", bus_if.wdt, 0);

    // Always-ready copy of four known words.
    for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    run_copy(32'h0, 32'h100, 16'd4, -1);

    run_copy(32'h20, 32'h120, 16'd0, -1);

    // Backpressure with random data.
    stall_en = 1;
    for (int i = 0; i < 8; i++) mem[32'h200 + 32'(4 * i)] = $urandom;
    run_copy(32'h200, 32'h300, 16'd8, -1);
    stall_en = 0;

    run_copy(32'h3, 32'hFFFF_FFFC, 16'd2, -1);

    // Second start mid-transfer is ignored.
    run_copy(32'h500, 32'h600, 16'd6, 4);

    // Reset during the first write of a five-word copy.
    @(negedge clk);
    src = 32'h700; dst = 32'h800; len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!(bus_if.vld && bus_if.wen) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("rst_wr_seen", {31'd0, bus_if.vld && bus_if.wen}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_vld", {31'd0, bus_if.vld}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    check("midrst_quiet", done_n, 0);
    run_copy(32'h900, 32'hA00, 16'd5, -1);

    // Random copies, including overlapping ascending regions.
    stall_en = 1;
    for (int t = 0; t < 5; t++) begin
      logic [31:0] s, d;
      s = 32'h1000 + 32'($urandom_range(0, 63));
      d = (t % 2 == 0) ? s + 32'($urandom_range(1, 3) * 4) : 32'($urandom);
      run_copy(s, d, 16'($urandom_range(0, 10)), -1);
    end
    stall_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
